pipe_control: RTL and testbench

PIPE_CONTROL -- requirements
Module: pipe_control

---
 rtl/pipe_control_pkg.sv | 92 +++++++++
 rtl/pipe_control_stage.sv | 77 +++++++
 rtl/pipe_control.sv | 154 +++++++++++++++
 tb/tb_pipe_control.sv | 316 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_control_pkg.sv
// -----------------------------------------------------------------------------
// pipe_control_pkg
// Shared definitions for the in-order pipeline control path: opcode values,
// control-word bit positions, the control-word width and the instruction
// decoder used by the decode stage.
// No ports (package).
// -----------------------------------------------------------------------------
package pipe_control_pkg;

   // Control word width and bit positions (bit 8 is the MSB).
   localparam int CW            = 9;
   localparam int CB_REG_WRITE  = 8;
   localparam int CB_MEM_TO_REG = 7;
   localparam int CB_MEM_READ   = 6;
   localparam int CB_MEM_WRITE  = 5;
   localparam int CB_BRANCH     = 4;
   localparam int CB_JUMP       = 3;
   localparam int CB_ALU_SRC    = 2;
   localparam int CB_REG_DST    = 1;
   localparam int CB_HALT       = 0;

   typedef enum logic [3:0] {
      OP_ADD  = 4'd0,
      OP_SUB  = 4'd1,
      OP_AND  = 4'd2,
      OP_OR   = 4'd3,
      OP_LW   = 4'd4,
      OP_SW   = 4'd5,
      OP_BEQ  = 4'd6,
      OP_JMP  = 4'd7,
      OP_HALT = 4'd14,
      OP_NOP  = 4'd15
   } opcode_e;

   typedef struct packed {
      logic [CW-1:0] ctrl;
      logic [1:0]    aluop;
      logic          illegal;
   } decode_t;

   // op_lo is the low nibble of the opcode; op_hi flags any set bit above it,
   // which makes the opcode illegal regardless of the nibble.
   function automatic decode_t decode(input logic [3:0] op_lo, input logic op_hi);
      decode_t d;
      d = '0;
      if (op_hi) begin
         d.illegal = 1'b1;
      end else begin
         case (op_lo)
            OP_ADD: begin
               d.ctrl[CB_REG_WRITE] = 1'b1;
               d.ctrl[CB_REG_DST]   = 1'b1;
            end
            OP_SUB: begin
               d.ctrl[CB_REG_WRITE] = 1'b1;
               d.ctrl[CB_REG_DST]   = 1'b1;
               d.aluop              = 2'b01;
            end
            OP_AND: begin
               d.ctrl[CB_REG_WRITE] = 1'b1;
               d.ctrl[CB_REG_DST]   = 1'b1;
               d.aluop              = 2'b10;
            end
            OP_OR: begin
               d.ctrl[CB_REG_WRITE] = 1'b1;
               d.ctrl[CB_REG_DST]   = 1'b1;
               d.aluop              = 2'b11;
            end
            OP_LW: begin
               d.ctrl[CB_REG_WRITE]  = 1'b1;
               d.ctrl[CB_MEM_TO_REG] = 1'b1;
               d.ctrl[CB_MEM_READ]   = 1'b1;
               d.ctrl[CB_ALU_SRC]    = 1'b1;
            end
            OP_SW: begin
               d.ctrl[CB_MEM_WRITE] = 1'b1;
               d.ctrl[CB_ALU_SRC]   = 1'b1;
            end
            OP_BEQ: begin
               d.ctrl[CB_BRANCH] = 1'b1;
               d.aluop           = 2'b01;
            end
            OP_JMP:  d.ctrl[CB_JUMP] = 1'b1;
            OP_HALT: d.ctrl[CB_HALT] = 1'b1;
            OP_NOP:  d.ctrl          = '0;
            default: d.illegal       = 1'b1;
         endcase
      end
      return d;
   endfunction

endpackage

// File: rtl/pipe_control_stage.sv
// -----------------------------------------------------------------------------
// pipe_control_stage
// One control pipeline register (valid, control word, ALU op, destination).
// kill forces a bubble and overrides hold; hold keeps the current contents;
// otherwise the stage loads its input.
// Ports:
//   clk, rst        clock, synchronous active-high reset (reset = bubble)
//   hold_i, kill_i  freeze / force-bubble controls
//   *_i             next contents offered by the upstream stage
//   *_o             current stage contents
// -----------------------------------------------------------------------------
module pipe_control_stage
   import pipe_control_pkg::*;
#(
   parameter int REGW = 3
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            hold_i,
   input  logic            kill_i,
   input  logic            valid_i,
   input  logic [CW-1:0]   ctrl_i,
   input  logic [1:0]      aluop_i,
   input  logic [REGW-1:0] dst_i,
   output logic            valid_o,
   output logic [CW-1:0]   ctrl_o,
   output logic [1:0]      aluop_o,
   output logic [REGW-1:0] dst_o
);

   logic            valid_q, valid_d;
   logic [CW-1:0]   ctrl_q,  ctrl_d;
   logic [1:0]      aluop_q, aluop_d;
   logic [REGW-1:0] dst_q,   dst_d;

   always_comb begin
      // NOTE: next-state defaults to the current value before any branch, so
      // every path assigns every signal and no latch is inferred.
      valid_d = valid_q;
      ctrl_d  = ctrl_q;
      aluop_d = aluop_q;
      dst_d   = dst_q;
      if (kill_i) begin
         valid_d = 1'b0;
         ctrl_d  = '0;
         aluop_d = '0;
         dst_d   = '0;
      end else if (!hold_i) begin
         valid_d = valid_i;
         ctrl_d  = ctrl_i;
         aluop_d = aluop_i;
         dst_d   = dst_i;
      end
   end

   // NOTE: state is updated with non-blocking assignments; every field, not
   // only valid, is reset because a bubble is defined as all-zero contents.
   always_ff @(posedge clk) begin
      if (rst) begin
         valid_q <= 1'b0;
         ctrl_q  <= '0;
         aluop_q <= '0;
         dst_q   <= '0;
      end else begin
         valid_q <= valid_d;
         ctrl_q  <= ctrl_d;
         aluop_q <= aluop_d;
         dst_q   <= dst_d;
      end
   end

   assign valid_o = valid_q;
   assign ctrl_o  = ctrl_q;
   assign aluop_o = aluop_q;
   assign dst_o   = dst_q;

endmodule

// File: rtl/pipe_control.sv
// -----------------------------------------------------------------------------
// pipe_control
// Decode-stage control for an in-order pipeline: decodes the instruction,
// detects load-use hazards, and drives STAGES control registers (EX, MEM,
// WB, ...) with stall, flush, bubble insertion and a sticky HALT.
// Ports:
//   clk, rst              clock, synchronous active-high reset
//   in_valid / in_ready   decode-stage handshake
//   opcode, rs, rt, rd    instruction fields
//   stall, flush          external freeze / branch-taken kill
//   stage_valid/ctrl/aluop/dst  per-stage contents, stage 0 (EX) in the LSBs
//   illegal               pulse, aligned with the illegal instruction in EX
//   bubble_cnt            saturating count of load-use bubbles
// -----------------------------------------------------------------------------
module pipe_control
   import pipe_control_pkg::*;
#(
   parameter int OPW         = 4,
   parameter int REGW        = 3,
   parameter int STAGES      = 3,
   parameter int FLUSH_DEPTH = 2
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   in_valid,
   output logic                   in_ready,
   input  logic [OPW-1:0]         opcode,
   input  logic [REGW-1:0]        rs,
   input  logic [REGW-1:0]        rt,
   input  logic [REGW-1:0]        rd,
   input  logic                   stall,
   input  logic                   flush,
   output logic [STAGES-1:0]      stage_valid,
   output logic [STAGES*CW-1:0]   stage_ctrl,
   output logic [STAGES*2-1:0]    stage_aluop,
   output logic [STAGES*REGW-1:0] stage_dst,
   output logic                   illegal,
   output logic [15:0]            bubble_cnt
);

   // Current stage contents.
   logic [STAGES-1:0]           s_valid;
   logic [STAGES-1:0][CW-1:0]   s_ctrl;
   logic [STAGES-1:0][1:0]      s_aluop;
   logic [STAGES-1:0][REGW-1:0] s_dst;

   // Contents offered to each stage and per-stage kill.
   logic [STAGES-1:0]           d_valid;
   logic [STAGES-1:0][CW-1:0]   d_ctrl;
   logic [STAGES-1:0][1:0]      d_aluop;
   logic [STAGES-1:0][REGW-1:0] d_dst;
   logic [STAGES-1:0]           kill;

   logic            illegal_q, illegal_d;
   logic            halt_q, halt_d;
   logic [15:0]     bubble_cnt_q, bubble_cnt_d;

   logic [3:0]      op_lo;
   logic            op_hi;
   decode_t         dec;
   logic [REGW-1:0] dec_dst;
   logic            hazard;
   logic            halted;
   logic            accept;

   assign op_lo   = 4'(opcode);
   assign op_hi   = |(opcode >> 4);
   assign dec     = decode(op_lo, op_hi);
   assign dec_dst = dec.ctrl[CB_REG_DST] ? rd : rt;

   // Load in EX whose result the decode instruction needs next cycle.
   assign hazard = s_valid[0] & s_ctrl[0][CB_MEM_READ] & in_valid &
                   ((s_dst[0] == rs) | (s_dst[0] == rt));

   // Halted from the cycle a HALT sits in the last stage, and for good after.
   assign halted   = halt_q | (s_valid[STAGES-1] & s_ctrl[STAGES-1][CB_HALT]);
   assign in_ready = ~stall & ~hazard & ~flush & ~halted;
   assign accept   = in_valid & in_ready;

   always_comb begin
      d_valid = '0;
      d_ctrl  = '0;
      d_aluop = '0;
      d_dst   = '0;
      kill    = '0;

      // Stage 0 takes the decoded instruction, or a bubble when nothing is
      // accepted (hazard, flush, halt or no instruction).
      d_valid[0] = accept;
      if (accept) begin
         d_ctrl[0]  = dec.ctrl;
         d_aluop[0] = dec.aluop;
         d_dst[0]   = dec_dst;
      end

      for (int k = 1; k < STAGES; k++) begin
         d_valid[k] = s_valid[k-1];
         d_ctrl[k]  = s_ctrl[k-1];
         d_aluop[k] = s_aluop[k-1];
         d_dst[k]   = s_dst[k-1];
      end

      // Flush kills the decode slot plus the youngest FLUSH_DEPTH-1 stages.
      for (int k = 0; k < STAGES; k++) begin
         kill[k] = flush && (k < FLUSH_DEPTH - 1);
      end

      illegal_d    = accept & dec.illegal;
      halt_d       = halted;
      bubble_cnt_d = bubble_cnt_q;
      if (hazard && !stall && !flush && (bubble_cnt_q != 16'hFFFF)) begin
         bubble_cnt_d = bubble_cnt_q + 16'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         illegal_q    <= 1'b0;
         halt_q       <= 1'b0;
         bubble_cnt_q <= '0;
      end else begin
         illegal_q    <= illegal_d;
         halt_q       <= halt_d;
         bubble_cnt_q <= bubble_cnt_d;
      end
   end

   for (genvar k = 0; k < STAGES; k++) begin : g_stage
      pipe_control_stage #(
         .REGW (REGW)
      ) u_stage (
         .clk     (clk),
         .rst     (rst),
         .hold_i  (stall),
         .kill_i  (kill[k]),
         .valid_i (d_valid[k]),
         .ctrl_i  (d_ctrl[k]),
         .aluop_i (d_aluop[k]),
         .dst_i   (d_dst[k]),
         .valid_o (s_valid[k]),
         .ctrl_o  (s_ctrl[k]),
         .aluop_o (s_aluop[k]),
         .dst_o   (s_dst[k])
      );
   end

   assign stage_valid = s_valid;
   assign stage_ctrl  = s_ctrl;
   assign stage_aluop = s_aluop;
   assign stage_dst   = s_dst;
   assign illegal     = illegal_q;
   assign bubble_cnt  = bubble_cnt_q;

endmodule

// File: tb/tb_pipe_control.sv
// -----------------------------------------------------------------------------
// tb_pipe_control
// Directed stimulus for pipe_control with a behavioural reference model of the
// control pipeline checked every cycle, plus literal expectations per scenario.
// -----------------------------------------------------------------------------
module tb_pipe_control;

   localparam int OPW         = 4;
   localparam int REGW        = 3;
   localparam int STAGES      = 3;
   localparam int FLUSH_DEPTH = 2;

   logic                   clk = 1'b0;
   logic                   rst;
   logic                   in_valid;
   logic                   in_ready;
   logic [OPW-1:0]         opcode;
   logic [REGW-1:0]        rs, rt, rd;
   logic                   stall, flush;
   logic [STAGES-1:0]      stage_valid;
   logic [STAGES*9-1:0]    stage_ctrl;
   logic [STAGES*2-1:0]    stage_aluop;
   logic [STAGES*REGW-1:0] stage_dst;
   logic                   illegal;
   logic [15:0]            bubble_cnt;

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   pipe_control #(
      .OPW         (OPW),
      .REGW        (REGW),
      .STAGES      (STAGES),
      .FLUSH_DEPTH (FLUSH_DEPTH)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .opcode      (opcode),
      .rs          (rs),
      .rt          (rt),
      .rd          (rd),
      .stall       (stall),
      .flush       (flush),
      .stage_valid (stage_valid),
      .stage_ctrl  (stage_ctrl),
      .stage_aluop (stage_aluop),
      .stage_dst   (stage_dst),
      .illegal     (illegal),
      .bubble_cnt  (bubble_cnt)
   );

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // ---------------------------------------------------------------------------
   // Reference model: an array of instruction records, one per stage.
   // ---------------------------------------------------------------------------
   typedef struct {
      bit            v;
      bit [8:0]      c;
      bit [1:0]      a;
      bit [REGW-1:0] d;
   } ins_t;

   ins_t m_st [STAGES];
   bit   m_halt = 1'b0;
   bit   m_ill  = 1'b0;
   int   m_cnt  = 0;
   bit   m_live = 1'b0;

   // Decode table written straight from the instruction list.
   function automatic ins_t ref_decode(input int op, input bit [REGW-1:0] t,
                                       input bit [REGW-1:0] d, output bit ill);
      ins_t r;
      r = '{default: 0};
      ill = 1'b0;
      case (op)
         0:  begin r.c = 9'b100000010; r.a = 2'b00; end
         1:  begin r.c = 9'b100000010; r.a = 2'b01; end
         2:  begin r.c = 9'b100000010; r.a = 2'b10; end
         3:  begin r.c = 9'b100000010; r.a = 2'b11; end
         4:  begin r.c = 9'b111000100; r.a = 2'b00; end
         5:  begin r.c = 9'b000100100; r.a = 2'b00; end
         6:  begin r.c = 9'b000010000; r.a = 2'b01; end
         7:  begin r.c = 9'b000001000; r.a = 2'b00; end
         14: begin r.c = 9'b000000001; r.a = 2'b00; end
         15: begin r.c = 9'b000000000; r.a = 2'b00; end
         default: ill = 1'b1;
      endcase
      r.v = 1'b1;
      r.d = r.c[1] ? d : t;
      return r;
   endfunction

   function automatic bit m_halted();
      return m_halt || (m_st[STAGES-1].v && m_st[STAGES-1].c[0]);
   endfunction

   function automatic bit m_hazard();
      return m_st[0].v && m_st[0].c[6] && in_valid &&
             (m_st[0].d == rs || m_st[0].d == rt);
   endfunction

   function automatic bit m_ready();
      return !stall && !m_hazard() && !flush && !m_halted();
   endfunction

   always @(posedge clk) begin : model
      ins_t nxt [STAGES];
      ins_t bub, fresh;
      bit   acc, f_ill;
      bub = '{default: 0};
      if (rst) begin
         for (int k = 0; k < STAGES; k++) m_st[k] <= bub;
         m_halt <= 1'b0;
         m_ill  <= 1'b0;
         m_cnt  <= 0;
         m_live <= 1'b1;
      end else begin
         acc   = in_valid && m_ready();
         fresh = ref_decode(int'(opcode), rt, rd, f_ill);
         for (int k = 0; k < STAGES; k++) nxt[k] = m_st[k];
         if (!stall) begin
            nxt[0] = acc ? fresh : bub;
            for (int k = 1; k < STAGES; k++) nxt[k] = m_st[k-1];
         end
         if (flush) begin
            for (int k = 0; k < FLUSH_DEPTH - 1; k++) nxt[k] = bub;
         end
         for (int k = 0; k < STAGES; k++) m_st[k] <= nxt[k];
         m_ill  <= acc && f_ill;
         m_halt <= m_halted();
         if (m_hazard() && !stall && !flush && m_cnt < 65535) m_cnt <= m_cnt + 1;
      end
   end

   // Every-cycle comparison of the DUT against the model, away from the edge.
   always @(negedge clk) begin
      if (m_live) begin
         for (int k = 0; k < STAGES; k++) begin
            check($sformatf("m_valid[%0d]", k), 64'(stage_valid[k]), 64'(m_st[k].v));
            check($sformatf("m_ctrl[%0d]", k), 64'(stage_ctrl[k*9 +: 9]), 64'(m_st[k].c));
            check($sformatf("m_aluop[%0d]", k), 64'(stage_aluop[k*2 +: 2]), 64'(m_st[k].a));
            check($sformatf("m_dst[%0d]", k), 64'(stage_dst[k*REGW +: REGW]), 64'(m_st[k].d));
         end
         check("m_illegal", 64'(illegal), 64'(m_ill));
         check("m_bubble_cnt", 64'(bubble_cnt), 64'(m_cnt));
         check("m_in_ready", 64'(in_ready), 64'(m_ready()));
      end
   end

   // ---------------------------------------------------------------------------
   // Directed stimulus with literal expectations.
   // ---------------------------------------------------------------------------
   task automatic drive(input bit v, input int op, input int s, input int t, input int d);
      in_valid = v;
      opcode   = OPW'(op);
      rs       = REGW'(s);
      rt       = REGW'(t);
      rd       = REGW'(d);
   endtask

   task automatic tick(input int n = 1);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   initial begin
      rst   = 1'b1;
      stall = 1'b0;
      flush = 1'b0;
      drive(0, 15, 0, 0, 0);
      tick(2);
      rst = 1'b0;

      // ADD r3 walks through the stages.
      drive(1, 0, 1, 2, 3);
      #1 check("rst_in_ready", 64'(in_ready), 64'd1);
      tick();
      drive(0, 15, 0, 0, 0);
      check("add_valid_c1", 64'(stage_valid), 64'b001);
      check("add_ctrl", 64'(stage_ctrl[8:0]), 64'b100000010);
      check("add_dst", 64'(stage_dst[2:0]), 64'd3);
      tick();
      check("add_valid_c2", 64'(stage_valid), 64'b010);
      tick();
      check("add_valid_c3", 64'(stage_valid), 64'b100);

      // LW r2 followed by dependent SUB: one bubble.
      drive(1, 4, 0, 2, 5);
      tick();
      check("lw_dst", 64'(stage_dst[2:0]), 64'd2);
      drive(1, 1, 2, 1, 4);
      #1 check("hazard_in_ready", 64'(in_ready), 64'd0);
      tick();
      check("hazard_valid", 64'(stage_valid), 64'b010);
      check("hazard_cnt", 64'(bubble_cnt), 64'd1);
      check("hazard_clear_ready", 64'(in_ready), 64'd1);
      tick();
      drive(0, 15, 0, 0, 0);
      check("sub_valid", 64'(stage_valid), 64'b101);
      check("sub_ctrl", 64'(stage_ctrl[8:0]), 64'b100000010);
      check("sub_aluop", 64'(stage_aluop[1:0]), 64'b01);
      check("sub_dst", 64'(stage_dst[2:0]), 64'd4);

      // Illegal opcode 9.
      drive(1, 9, 0, 0, 0);
      tick();
      drive(0, 15, 0, 0, 0);
      check("illegal_pulse", 64'(illegal), 64'd1);
      check("illegal_valid0", 64'(stage_valid[0]), 64'd1);
      check("illegal_ctrl0", 64'(stage_ctrl[8:0]), 64'd0);
      tick();
      check("illegal_gone", 64'(illegal), 64'd0);

      // Fill: ADD r1, OR r2, SW (dst = rt = 5).
      drive(1, 0, 0, 0, 1);
      tick();
      drive(1, 3, 0, 0, 2);
      tick();
      drive(1, 5, 0, 5, 7);
      tick();
      check("full_valid", 64'(stage_valid), 64'b111);
      check("full_dst", 64'(stage_dst), 64'({3'd1, 3'd2, 3'd5}));
      check("full_ctrl", 64'(stage_ctrl), 64'({9'b100000010, 9'b100000010, 9'b000100100}));

      // Stall for three cycles with an instruction waiting.
      drive(1, 0, 0, 0, 6);
      stall = 1'b1;
      #1 check("stall_in_ready", 64'(in_ready), 64'd0);
      for (int i = 0; i < 3; i++) begin
         tick();
         check($sformatf("stall_valid_%0d", i), 64'(stage_valid), 64'b111);
         check($sformatf("stall_dst_%0d", i), 64'(stage_dst), 64'({3'd1, 3'd2, 3'd5}));
         check($sformatf("stall_ctrl_%0d", i), 64'(stage_ctrl),
               64'({9'b100000010, 9'b100000010, 9'b000100100}));
         check($sformatf("stall_cnt_%0d", i), 64'(bubble_cnt), 64'd1);
      end
      stall = 1'b0;
      tick();
      check("resume_dst", 64'(stage_dst), 64'({3'd2, 3'd5, 3'd6}));

      // Flush with full pipe: stage 0 and decode killed, older stages advance.
      drive(1, 0, 0, 0, 7);
      flush = 1'b1;
      #1 check("flush_in_ready", 64'(in_ready), 64'd0);
      tick();
      flush = 1'b0;
      check("flush_valid", 64'(stage_valid), 64'b110);
      check("flush_dst", 64'(stage_dst), 64'({3'd5, 3'd6, 3'd0}));

      // Flush together with stall: stage 0 killed, others hold.
      drive(1, 0, 0, 0, 3);
      tick();
      drive(0, 15, 0, 0, 0);
      check("pre_fs_valid", 64'(stage_valid), 64'b101);
      stall = 1'b1;
      flush = 1'b1;
      tick();
      stall = 1'b0;
      flush = 1'b0;
      check("fs_valid", 64'(stage_valid), 64'b100);
      check("fs_dst", 64'(stage_dst), 64'({3'd6, 3'd0, 3'd0}));

      // HALT reaches the last stage, then reset mid-stream.
      drive(1, 14, 0, 0, 0);
      tick();
      drive(1, 2, 0, 0, 4);
      tick();
      drive(1, 3, 0, 0, 5);
      tick();
      check("halt_last_ctrl", 64'(stage_ctrl[26:18]), 64'b000000001);
      check("halt_full_valid", 64'(stage_valid), 64'b111);
      drive(1, 0, 0, 0, 1);
      #1 check("halt_in_ready", 64'(in_ready), 64'd0);
      rst = 1'b1;
      tick();
      check("rst_valid", 64'(stage_valid), 64'd0);
      check("rst_cnt", 64'(bubble_cnt), 64'd0);
      check("rst_illegal", 64'(illegal), 64'd0);
      rst = 1'b0;
      #1 check("post_rst_ready", 64'(in_ready), 64'd1);
      tick();
      check("post_rst_valid", 64'(stage_valid), 64'b001);

      // HALT latch keeps in_ready low after the HALT drains.
      drive(1, 14, 0, 0, 0);
      tick();
      drive(1, 0, 0, 0, 2);
      tick();
      drive(0, 15, 0, 0, 0);
      tick();
      drive(1, 0, 0, 0, 3);
      #1 check("halt2_in_ready", 64'(in_ready), 64'd0);
      tick();
      check("halt_latch_ready", 64'(in_ready), 64'd0);
      check("halt_drain_valid", 64'(stage_valid), 64'b100);
      drive(0, 15, 0, 0, 0);
      tick(2);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
